// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and the writeback entry payload for the register-file write queue.
package regfile_wb_queue_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback enqueue, register-file write port and operand read/bypass signals.
interface regfile_wb_queue_if
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_reg;
  logic [DATA_W-1:0] enq_data;
  logic              rf_hold;
  logic              WriteReg;
  logic [ADDR_W-1:0] DstReg;
  logic [DATA_W-1:0] DstData;
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [DATA_W-1:0] RfData1;
  logic [DATA_W-1:0] RfData2;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic [CNT_W-1:0]  count;

  // Queue side: drives the register-file write port and the bypassed operands.
  modport master (
    input  enq_valid, enq_reg, enq_data, rf_hold,
    input  SrcReg1, SrcReg2, RfData1, RfData2,
    output enq_ready, WriteReg, DstReg, DstData,
    output SrcData1, SrcData2, count
  );

  // Pipeline / register-file side.
  modport slave (
    output enq_valid, enq_reg, enq_data, rf_hold,
    output SrcReg1, SrcReg2, RfData1, RfData2,
    input  enq_ready, WriteReg, DstReg, DstData,
    input  SrcData1, SrcData2, count
  );

endinterface

// File: rtl/regfile_wb_queue_bypass_match.sv
// Operand bypass for one read port: newest pending write to the source register wins.
module wb_bypass_match
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH),
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t         entries_i [DEPTH],
  input  logic [PTR_W-1:0]  head_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              enq_i,
  input  logic [ADDR_W-1:0] enq_reg_i,
  input  logic [DATA_W-1:0] enq_data_i,
  input  logic [ADDR_W-1:0] src_reg_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so a later match overrides; the incoming write overrides all.
  always_comb begin
    data_o = rf_data_i;
    slot   = head_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = PTR_W'(head_i + PTR_W'(i));
      if ((CNT_W'(i) < count_i) && (entries_i[slot].dst == src_reg_i)) begin
        data_o = entries_i[slot].data;
      end
    end
    if (enq_i && (enq_reg_i == src_reg_i)) begin
      data_o = enq_data_i;
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue draining one entry per cycle into the register file,
// with write-before-read bypass on both operand ports.
module regfile_wb_queue
  import regfile_wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_queue_if.master wb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain_c;
  logic             ready_c;
  logic             enq_c;
  wb_entry_t        head_entry_c;

  // Handshake and pointer next-state.
  always_comb begin
    drain_c      = (count_q != '0) && !wb.rf_hold;
    ready_c      = rst && ((count_q < CNT_W'(DEPTH)) || drain_c);
    enq_c        = wb.enq_valid && ready_c;
    head_entry_c = (count_q != '0) ? mem_q[head_q] : '0;
    head_d       = drain_c ? PTR_W'(head_q + PTR_W'(1)) : head_q;
    tail_d       = enq_c   ? PTR_W'(tail_q + PTR_W'(1)) : tail_q;
    count_d      = CNT_W'(count_q + CNT_W'(enq_c) - CNT_W'(drain_c));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: slots outside [head, head+count) are never observed.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      mem_q[tail_q] <= '{dst: wb.enq_reg, data: wb.enq_data};
    end
  end

  assign wb.enq_ready = ready_c;
  assign wb.WriteReg  = drain_c;
  assign wb.DstReg    = head_entry_c.dst;
  assign wb.DstData   = head_entry_c.data;
  assign wb.count     = count_q;

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .enq_i     (enq_c),
    .enq_reg_i (wb.enq_reg),
    .enq_data_i(wb.enq_data),
    .src_reg_i (wb.SrcReg1),
    .rf_data_i (wb.RfData1),
    .data_o    (wb.SrcData1)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .enq_i     (enq_c),
    .enq_reg_i (wb.enq_reg),
    .enq_data_i(wb.enq_data),
    .src_reg_i (wb.SrcReg2),
    .rf_data_i (wb.RfData2),
    .data_o    (wb.SrcData2)
  );

endmodule
